// File: rtl/uart_pkg.sv
// Shared constants for the UART host master.
// Slave register map, status bit index and FSM state encoding.
package uart_pkg;

    localparam logic [3:0] REG_TX   = 4'd0;
    localparam logic [3:0] REG_STAT = 4'd1;
    localparam logic [3:0] REG_RX   = 4'd2;

    localparam int unsigned STAT_TX_RDY = 0;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_RX_RD  = 3'd1;
    localparam state_t S_RX_CAP = 3'd2;
    localparam state_t S_ST_RD  = 3'd3;
    localparam state_t S_ST_CAP = 3'd4;
    localparam state_t S_TX_WR  = 3'd5;
    localparam state_t S_TX_GAP = 3'd6;

endpackage

// File: rtl/uart_host_master_if.sv
// Signal bundle between a host stream, the UART host master
// and an Avalon-MM UART slave.
interface uart_host_master_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic [3:0] avm_address;
    logic       avm_read;
    logic       avm_write;
    logic [7:0] avm_writedata;
    logic [7:0] avm_readdata;
    logic       irq;
    logic       busy;

    modport master (
        input  s_data, s_valid, avm_readdata, irq,
        output s_ready, m_data, m_valid, busy,
        output avm_address, avm_read, avm_write, avm_writedata
    );

    modport slave (
        output s_data, s_valid, avm_readdata, irq,
        input  s_ready, m_data, m_valid, busy,
        input  avm_address, avm_read, avm_write, avm_writedata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth.
// A push while full is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_FULL);
    assign empty_o = (count == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/uart_host_master.sv
// Host-side master for an Avalon-MM UART: drains a TX byte buffer
// under status polling and services RX interrupts first.
module uart_host_master
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    output logic [3:0] avm_address_o,
    output logic       avm_read_o,
    output logic       avm_write_o,
    output logic [7:0] avm_writedata_o,
    input  logic [7:0] avm_readdata_i,
    input  logic       irq_i,
    output logic       busy_o
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GUARD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] gap_cnt;
    logic          irq_q;
    logic          irq_pend;
    logic          irq_rise;
    logic          rdy_en;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_head;

    assign irq_rise  = irq_i && !irq_q;
    assign fifo_pop  = (state == S_TX_WR);
    assign s_ready_o = rdy_en && (!fifo_full || fifo_pop);
    assign fifo_push = s_valid_i && s_ready_o;
    assign busy_o    = (state != S_IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (fifo_push),
        .data_i (s_data_i),
        .pop_i  (fifo_pop),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (irq_pend)         state_nxt = S_RX_RD;
                else if (!fifo_empty) state_nxt = S_ST_RD;
            end
            S_RX_RD:  state_nxt = S_RX_CAP;
            S_RX_CAP: state_nxt = S_IDLE;
            S_ST_RD:  state_nxt = S_ST_CAP;
            S_ST_CAP: begin
                // Not ready: back to IDLE so a pending RX can cut in.
                if (avm_readdata_i[STAT_TX_RDY]) state_nxt = S_TX_WR;
                else                             state_nxt = S_IDLE;
            end
            S_TX_WR:  state_nxt = S_TX_GAP;
            S_TX_GAP: begin
                if (gap_cnt == '0) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read_o      = 1'b0;
        avm_write_o     = 1'b0;
        avm_address_o   = '0;
        avm_writedata_o = '0;
        case (state)
            S_RX_RD: begin
                avm_read_o    = 1'b1;
                avm_address_o = REG_RX;
            end
            S_ST_RD: begin
                avm_read_o    = 1'b1;
                avm_address_o = REG_STAT;
            end
            S_TX_WR: begin
                avm_write_o     = 1'b1;
                avm_address_o   = REG_TX;
                avm_writedata_o = fifo_head;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // Track irq through reset so a level held across it is no edge.
        irq_q <= irq_i;
        if (rst_i) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            irq_pend  <= 1'b0;
            rdy_en    <= 1'b0;
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            rdy_en    <= 1'b1;
            m_valid_o <= (state == S_RX_CAP);
            if (state == S_RX_CAP) m_data_o <= avm_readdata_i;
            if (irq_rise)                irq_pend <= 1'b1;
            else if (state == S_RX_RD)   irq_pend <= 1'b0;
            if (state == S_TX_WR)
                gap_cnt <= GAP_LOAD;
            else if (state == S_TX_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_ONE;
        end
    end

endmodule

// File: tb/tb_uart_host_master.sv
// Self-checking bench for uart_host_master: directed scenarios plus
// randomized traffic against a queue-based UART slave model.
module tb_uart_host_master;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int GUARD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_host_master_if u();

    uart_host_master #(
        .FIFO_DEPTH  (DEPTH),
        .GUARD_CYCLES(GUARD)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .s_data_i       (u.s_data),
        .s_valid_i      (u.s_valid),
        .s_ready_o      (u.s_ready),
        .m_data_o       (u.m_data),
        .m_valid_o      (u.m_valid),
        .avm_address_o  (u.avm_address),
        .avm_read_o     (u.avm_read),
        .avm_write_o    (u.avm_write),
        .avm_writedata_o(u.avm_writedata),
        .avm_readdata_i (u.avm_readdata),
        .irq_i          (u.irq),
        .busy_o         (u.busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_stat = 0;
    int n_rx = 0;
    int n_mv = 0;
    int acc_cyc = 0;
    int stat_mode = 1;
    int stat_hold = 0;
    int wr_times[$];
    logic [3:0] rd_addrs[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [31:0] exp_mdata = 32'h0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rd_val = 8'h00;
    logic rd_pend = 1'b0;
    logic last_stat = 1'b0;
    logic mv_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Slave read data appears in the cycle after the read strobe.
    always @(posedge clk) begin
        #1;
        u.avm_readdata = rd_pend ? rd_val : 8'h00;
    end

    always @(negedge clk) begin
        logic       sb;
        logic [31:0] e;
        if (rst) begin
            exp_tx.delete();
            exp_rx.delete();
            exp_mdata = 32'h0;
            rd_pend = 1'b0;
            last_stat = 1'b0;
            mv_prev = 1'b0;
        end else begin
            if (u.s_valid && u.s_ready) begin
                exp_tx.push_back(u.s_data);
                acc_cyc = cyc;
            end
            if (u.avm_read || u.avm_write)
                check("strobe_excl", {31'b0, u.avm_read & u.avm_write}, 0);
            else
                check("idle_bus", {20'b0, u.avm_address, u.avm_writedata}, 0);
            if (u.avm_write) begin
                n_wr++;
                wr_times.push_back(cyc);
                check("wr_addr", {28'b0, u.avm_address}, {28'b0, REG_TX});
                check("wr_after_rdy", {31'b0, last_stat}, 1);
                e = (exp_tx.size() > 0) ? {24'b0, exp_tx.pop_front()} : 32'hdead;
                check("wr_data", {24'b0, u.avm_writedata}, e);
                last_stat = 1'b0;
            end
            rd_pend = u.avm_read;
            if (u.avm_read) begin
                rd_addrs.push_back(u.avm_address);
                if (u.avm_address == REG_STAT) begin
                    if (n_stat < stat_hold) sb = 1'b0;
                    else if (stat_mode == 0) sb = 1'b0;
                    else if (stat_mode == 1) sb = 1'b1;
                    else sb = 1'($urandom_range(0, 1));
                    n_stat++;
                    rd_val = {7'($urandom), sb};
                    last_stat = sb;
                end else begin
                    check("rd_addr", {28'b0, u.avm_address}, {28'b0, REG_RX});
                    n_rx++;
                    rd_val = rx_byte;
                    exp_rx.push_back(rx_byte);
                    last_stat = 1'b0;
                end
            end
            if (u.m_valid) begin
                n_mv++;
                check("mv_pulse", {31'b0, mv_prev}, 0);
                exp_mdata = (exp_rx.size() > 0) ? {24'b0, exp_rx.pop_front()} : 32'h100;
            end
            check("m_data", {24'b0, u.m_data}, exp_mdata);
            mv_prev = u.m_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        u.s_valid = 1'b1;
        u.s_data = b;
        @(negedge clk);
        while (!u.s_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!u.s_ready) check("push_timeout", {31'b0, u.s_ready}, 1);
        tick();
        u.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            quiet = u.busy ? 0 : quiet + 1;
        end
        check("idle_timeout", {31'b0, u.busy}, 0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        u.s_valid = 1'b0;
        u.irq = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_ready", {31'b0, u.s_ready}, 0);
        check("rst_busy", {31'b0, u.busy}, 0);
        check("rst_mout", {23'b0, u.m_valid, u.m_data}, 0);
        check("rst_bus", {18'b0, u.avm_read, u.avm_write, u.avm_address,
                          u.avm_writedata}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready_lo", {31'b0, u.s_ready}, 0);
        @(negedge clk);
        check("rel_ready_hi", {31'b0, u.s_ready}, 1);
        tick();
    endtask

    initial begin
        int s0, s1, n, w0;
        u.s_valid = 1'b0;
        u.s_data = 8'h00;
        u.irq = 1'b0;
        do_reset();

        // Two bytes, status always ready: spacing of the writes.
        stat_mode = 1;
        w0 = wr_times.size();
        push(8'h48);
        push(8'h69);
        wait_idle();
        check("t1_nwr", wr_times.size() - w0, 2);
        if (wr_times.size() - w0 >= 2)
            check("t1_gap", wr_times[w0+1] - wr_times[w0] - 1, 3 + GUARD);

        // Five not-ready polls before the write goes out.
        s0 = n_stat;
        s1 = n_wr;
        stat_hold = n_stat + 5;
        push(8'h33);
        wait_idle();
        check("t2_polls", n_stat - s0, 6);
        check("t2_nwr", n_wr - s1, 1);

        // irq and a push together: RX read goes first.
        stat_mode = 0;
        rx_byte = 8'hA5;
        w0 = rd_addrs.size();
        u.s_valid = 1'b1;
        u.s_data = 8'h5A;
        u.irq = 1'b1;
        tick();
        u.s_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u.m_valid && n < 50);
        check("t3_mvalid", {31'b0, u.m_valid}, 1);
        check("t3_mdata", {24'b0, u.m_data}, 32'hA5);
        check("t3_first_rd",
              {28'b0, (rd_addrs.size() > w0) ? rd_addrs[w0] : 4'hF},
              {28'b0, REG_RX});
        tick();
        u.irq = 1'b0;
        stat_mode = 1;
        wait_idle();

        // Fill the buffer with TX blocked, then unblock.
        stat_mode = 0;
        s1 = n_wr;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
        @(negedge clk);
        check("t4_full", {31'b0, u.s_ready}, 0);
        repeat (3) tick();
        @(negedge clk);
        check("t4_full_hold", {31'b0, u.s_ready}, 0);
        tick();
        w0 = wr_times.size();
        stat_mode = 1;
        push(8'h20);
        check("t4_acc_after_wr",
              {31'b0, (wr_times.size() > w0) ? (acc_cyc >= wr_times[w0]) : 1'b0},
              1);
        wait_idle();
        check("t4_nwr", n_wr - s1, DEPTH + 1);

        // Reset during a write.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u.avm_write && n < 100);
        check("t5_saw_wr", {31'b0, u.avm_write}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_strobes", {30'b0, u.avm_read, u.avm_write}, 0);
        check("t5_busy", {31'b0, u.busy}, 0);
        check("t5_ready", {31'b0, u.s_ready}, 0);
        tick();
        rst = 1'b0;
        s1 = n_wr;
        repeat (40) tick();
        check("t5_no_wr", n_wr - s1, 0);
        check("t5_idle", {31'b0, u.busy}, 0);

        // irq edge lands in RX_RD: the set must win over the clear.
        s0 = n_rx;
        s1 = n_mv;
        rx_byte = 8'h3C;
        u.irq = 1'b1;
        tick();
        u.irq = 1'b0;
        tick();
        u.irq = 1'b1;
        @(negedge clk);
        check("t6_in_rxrd", {27'b0, u.avm_read, u.avm_address},
              {27'b0, 1'b1, REG_RX});
        tick();
        u.irq = 1'b0;
        wait_idle();
        check("t6_nrx", n_rx - s0, 2);
        check("t6_nmv", n_mv - s1, 2);

        // Random traffic.
        stat_mode = 2;
        for (int i = 0; i < 250; i++) begin
            rx_byte = 8'($urandom);
            case ($urandom_range(0, 3))
                0, 1: push(8'($urandom));
                2: begin
                    u.irq = 1'b1;
                    tick();
                    u.irq = 1'b0;
                end
                default: repeat ($urandom_range(1, 4)) tick();
            endcase
        end
        stat_mode = 1;
        wait_idle();
        repeat (5) tick();
        check("rnd_tx_drain", exp_tx.size(), 0);
        check("rnd_rx_drain", exp_rx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
